// File: rtl/fpro_arb_pkg.sv
// Shared types and widths for the FPro MMIO two-master arbiter.
package fpro_arb_pkg;
  localparam int FP_ADDR_W = 21;
  localparam int FP_DATA_W = 32;
  localparam int N_MASTERS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/arb_pick2.sv
// Combinational winner select for two masters.
// ARB_ROUND_ROBIN_EN selects round-robin; otherwise master 0 has fixed priority.
module arb_pick2
  import fpro_arb_pkg::*;
(
  input  logic [N_MASTERS-1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic                 ptr,
`endif
  output logic                 valid,
  output logic                 idx
);

  always_comb begin
    valid = |req;
`ifdef ARB_ROUND_ROBIN_EN
    // ptr names the master preferred on a tie, i.e. the one not served last
    idx = (req == 2'b11) ? ptr : req[1];
`else
    idx = ~req[0];
`endif
  end

endmodule

// File: rtl/fpro_mmio_arbiter.sv
// Serialises two masters onto the FPro MMIO bus via an IDLE/ISSUE/DONE sequencer.
// Build with ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority to master 0.
//
// state | meaning
// IDLE  | waiting for a request; latch the winner's fields on grant
// ISSUE | single bus cycle with mmio_cs high; read data captured at its end
// DONE  | one-cycle m_ack pulse to the granted master
module fpro_mmio_arbiter
  import fpro_arb_pkg::*;
#(
  parameter int ADDR_W = FP_ADDR_W,
  parameter int DATA_W = FP_DATA_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_MASTERS-1:0] m_req,
  input  logic [N_MASTERS-1:0] m_wr,
  input  logic [ADDR_W-1:0]    m_addr0,
  input  logic [ADDR_W-1:0]    m_addr1,
  input  logic [DATA_W-1:0]    m_wr_data0,
  input  logic [DATA_W-1:0]    m_wr_data1,
  output logic [N_MASTERS-1:0] m_ack,
  output logic [DATA_W-1:0]    m_rd_data,
  output logic                 mmio_cs,
  output logic                 mmio_wr,
  output logic                 mmio_rd,
  output logic [ADDR_W-1:0]    mmio_addr,
  output logic [DATA_W-1:0]    mmio_wr_data,
  input  logic [DATA_W-1:0]    mmio_rd_data
);

  arb_state_t state_q, state_d;
  logic       g_q;
  logic       wr_q;
  logic       pick_valid;
  logic       pick_idx;

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_q;

  arb_pick2 u_pick (
    .req   (m_req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ptr_q <= 1'b0;
    else if (state_q == DONE)
      ptr_q <= ~g_q;
  end
`else
  arb_pick2 u_pick (
    .req   (m_req),
    .valid (pick_valid),
    .idx   (pick_idx)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = ISSUE;
      ISSUE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes are registered from the grant decision so mmio_* never sees m_req combinationally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_q          <= 1'b0;
      wr_q         <= 1'b0;
      m_ack        <= '0;
      m_rd_data    <= '0;
      mmio_cs      <= 1'b0;
      mmio_wr      <= 1'b0;
      mmio_rd      <= 1'b0;
      mmio_addr    <= '0;
      mmio_wr_data <= '0;
    end else begin
      mmio_cs <= 1'b0;
      mmio_wr <= 1'b0;
      mmio_rd <= 1'b0;
      m_ack   <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            g_q          <= pick_idx;
            wr_q         <= m_wr[pick_idx];
            mmio_addr    <= pick_idx ? m_addr1 : m_addr0;
            mmio_wr_data <= pick_idx ? m_wr_data1 : m_wr_data0;
            mmio_cs      <= 1'b1;
            mmio_wr      <= m_wr[pick_idx];
            mmio_rd      <= ~m_wr[pick_idx];
          end
        end
        ISSUE: begin
          if (!wr_q)
            m_rd_data <= mmio_rd_data;
          m_ack[g_q] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpro_mmio_arbiter.sv
// Directed scoreboard bench for fpro_mmio_arbiter; expectations follow ARB_ROUND_ROBIN_EN.
module tb_fpro_mmio_arbiter;

  typedef struct packed {
    logic        wr;
    logic [20:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  m_req;
  logic [1:0]  m_wr;
  logic [20:0] m_addr0, m_addr1;
  logic [31:0] m_wr_data0, m_wr_data1;
  logic [1:0]  m_ack;
  logic [31:0] m_rd_data;
  logic        mmio_cs, mmio_wr, mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;

  txn_t        q0[$];
  txn_t        q1[$];
  int          grant_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cur_g = 0;
  txn_t        cur_t;
  logic        ack_due = 1'b0;
  logic [31:0] last_rd = 32'h0;

  always #5 clk = ~clk;

  function automatic logic [31:0] bus_fn(input logic [20:0] a);
    if (a == 21'h000C40) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign mmio_rd_data = bus_fn(mmio_addr);

  fpro_mmio_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .m_req        (m_req),
    .m_wr         (m_wr),
    .m_addr0      (m_addr0),
    .m_addr1      (m_addr1),
    .m_wr_data0   (m_wr_data0),
    .m_wr_data1   (m_wr_data1),
    .m_ack        (m_ack),
    .m_rd_data    (m_rd_data),
    .mmio_cs      (mmio_cs),
    .mmio_wr      (mmio_wr),
    .mmio_rd      (mmio_rd),
    .mmio_addr    (mmio_addr),
    .mmio_wr_data (mmio_wr_data),
    .mmio_rd_data (mmio_rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input int m);
    if (m == 0) begin
      if (q0.size() > 0) begin
        m_req[0] = 1'b1; m_wr[0] = q0[0].wr; m_addr0 = q0[0].addr; m_wr_data0 = q0[0].data;
      end else m_req[0] = 1'b0;
    end else begin
      if (q1.size() > 0) begin
        m_req[1] = 1'b1; m_wr[1] = q1[0].wr; m_addr1 = q1[0].addr; m_wr_data1 = q1[0].data;
      end else m_req[1] = 1'b0;
    end
  endtask

  task automatic push(input int m, input logic wr, input logic [20:0] a, input logic [31:0] d);
    txn_t t;
    t.wr = wr; t.addr = a; t.data = d;
    if (m == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  // One cycle: sample at negedge, score issue/ack, re-present or drop the acked request
  task automatic step();
    @(negedge clk);
    if (ack_due) begin
      ack_due = 1'b0;
      chk("ack_onehot", 32'(m_ack), (cur_g == 1) ? 32'h2 : 32'h1);
      if (!cur_t.wr) last_rd = bus_fn(cur_t.addr);
      chk("rd_data", m_rd_data, last_rd);
      if (cur_g == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      present(cur_g);
    end else if (m_ack != 2'b00) begin
      chk("spurious_ack", 32'(m_ack), 32'h0);
    end
    if (mmio_cs) begin
      if (grant_q.size() == 0) begin
        chk("spurious_cs", 32'(mmio_cs), 32'h0);
      end else begin
        cur_g = grant_q.pop_front();
        if ((cur_g == 0 && q0.size() == 0) || (cur_g == 1 && q1.size() == 0)) begin
          chk("grant_master", 32'(cur_g), 32'hFFFF_FFFF);
        end else begin
          cur_t = (cur_g == 0) ? q0[0] : q1[0];
          chk("issue_addr", 32'(mmio_addr), 32'(cur_t.addr));
          chk("issue_wr", 32'(mmio_wr), 32'(cur_t.wr));
          chk("issue_rd", 32'(mmio_rd), 32'(!cur_t.wr));
          if (cur_t.wr) chk("issue_wdata", mmio_wr_data, cur_t.data);
          ack_due = 1'b1;
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() + q1.size()) > 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(q0.size() + q1.size()), 32'h0);
  endtask

  task automatic single(input int m, input logic wr, input logic [20:0] a, input logic [31:0] d);
    step();
    push(m, wr, a, d);
    grant_q.push_back(m);
    present(m);
    step();
    chk("issue_latency", 32'(mmio_cs), 32'h1);
    step();
    chk("ack_latency", 32'(|m_ack), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    m_req = 2'b00; m_wr = 2'b00;
    m_addr0 = '0; m_addr1 = '0; m_wr_data0 = '0; m_wr_data1 = '0;

    // Reset with both requests held: nothing reaches the bus, then master 0 wins first
    push(0, 1'b0, 21'h000200, 32'h0);
    push(1, 1'b0, 21'h000300, 32'h0);
    grant_q.push_back(0);
    grant_q.push_back(1);
    present(0);
    present(1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_cs", 32'(mmio_cs), 32'h0);
      chk("rst_ack", 32'(m_ack), 32'h0);
    end
    chk("rst_wr_rd", 32'({mmio_wr, mmio_rd}), 32'h0);
    chk("rst_addr", 32'(mmio_addr), 32'h0);
    chk("rst_wdata", mmio_wr_data, 32'h0);
    chk("rst_rdata", m_rd_data, 32'h0);
    reset_n = 1'b1;
    drain(20);

    // Master 0 read returning DEADBEEF
    single(0, 1'b0, 21'h000C40, 32'h0);
    chk("rd_deadbeef", m_rd_data, 32'hDEAD_BEEF);

    // Master 1 write; read data register must keep its value
    single(1, 1'b1, 21'h000080, 32'h1234_5678);
    chk("rd_kept_on_write", m_rd_data, 32'hDEAD_BEEF);

    // Both masters held busy: arbitration order
    step();
    for (int i = 0; i < 4; i++)
      push(0, i[0], 21'h000400 + 21'(i * 4), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 2; i++)
      push(1, ~i[0], 21'h000500 + 21'(i * 4), 32'hB000_0000 + 32'(i));
`ifdef ARB_ROUND_ROBIN_EN
    grant_q = '{0, 1, 0, 1, 0, 0};
`else
    grant_q = '{0, 0, 0, 0, 1, 1};
`endif
    present(0);
    present(1);
    drain(60);
    chk("grant_order_consumed", 32'(grant_q.size()), 32'h0);

    // Address change after grant must not reach the bus
    step();
    push(0, 1'b0, 21'h000100, 32'h0);
    grant_q.push_back(0);
    present(0);
    step();
    chk("issue_latency_latch", 32'(mmio_cs), 32'h1);
    m_addr0 = 21'h1FFFFF;
    #1 chk("addr_latched_issue", 32'(mmio_addr), 32'h100);
    step();
    chk("addr_latched_done", 32'(mmio_addr), 32'h100);

    // Reset during ISSUE aborts without an ack
    step();
    push(0, 1'b0, 21'h000240, 32'h0);
    grant_q.push_back(0);
    present(0);
    step();
    chk("abort_issue_seen", 32'(mmio_cs), 32'h1);
    #2 reset_n = 1'b0;
    #1 chk("abort_cs_drop", 32'(mmio_cs), 32'h0);
    q0.delete();
    ack_due = 1'b0;
    m_req = 2'b00;
    last_rd = 32'h0;
    step();
    chk("abort_no_ack", 32'(m_ack), 32'h0);
    reset_n = 1'b1;
    step();
    step();
    chk("abort_idle_cs", 32'(mmio_cs), 32'h0);
    chk("abort_idle_ack", 32'(m_ack), 32'h0);
    chk("abort_rdata_clr", m_rd_data, 32'h0);

    // Recovery after abort
    single(1, 1'b0, 21'h000300, 32'h0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
